// File: rtl/counter_mod_n_updown_if.sv
`default_nettype none
// ============================================================================
//  Module      : counter_mod_n_updown_if
//  Description : Control/status bundle for counter_mod_n_updown.
//                master : the side that drives En/Up/Sat/Load/Load_Val and
//                         observes Count/Tc/Load_Err/Wraps.
//                slave  : the counter itself.
//                With COUNTER_OVF_STICKY_EN defined, the bundle also carries
//                Ovf_Clr (master -> slave) and Ovf (slave -> master).
//  Revision    : 1.0 - initial release
// ============================================================================
interface counter_mod_n_updown_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) ();
    logic              En;
    logic              Up;
    logic              Sat;
    logic              Load;
    logic [WIDTH-1:0]  Load_Val;
    logic [WIDTH-1:0]  Count;
    logic              Tc;
    logic              Load_Err;
    logic [WRAP_W-1:0] Wraps;
`ifdef COUNTER_OVF_STICKY_EN
    logic              Ovf_Clr;
    logic              Ovf;
`endif

    modport master (
        output En, Up, Sat, Load, Load_Val,
`ifdef COUNTER_OVF_STICKY_EN
        output Ovf_Clr,
        input  Ovf,
`endif
        input  Count, Tc, Load_Err, Wraps
    );

    modport slave (
        input  En, Up, Sat, Load, Load_Val,
`ifdef COUNTER_OVF_STICKY_EN
        input  Ovf_Clr,
        output Ovf,
`endif
        output Count, Tc, Load_Err, Wraps
    );
endinterface
`default_nettype wire

// File: rtl/counter_mod_n_updown.sv
`default_nettype none
// ============================================================================
//  Module      : counter_mod_n_updown
//  Description : Synchronous modulo-MODULUS up/down counter with enable,
//                parallel load, wrap/saturate mode, registered terminal-count
//                pulse, out-of-range load flag and saturating wrap counter.
//  Ports       : Clk      - rising-edge clock
//                Reset    - synchronous, active-high reset
//                bus      - counter_mod_n_updown_if.slave
//                           in : En, Up, Sat, Load, Load_Val [, Ovf_Clr]
//                           out: Count, Tc, Load_Err, Wraps [, Ovf]
//  Parameters  : WIDTH   - Count/Load_Val width (2**WIDTH >= MODULUS)
//                MODULUS - count range 0..MODULUS-1 (>= 2)
//                WRAP_W  - Wraps width
//  Options     : COUNTER_OVF_STICKY_EN - adds sticky Ovf flag set when a wrap
//                occurs while Wraps is already saturated, cleared by Ovf_Clr.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_mod_n_updown #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int WRAP_W  = 8
) (
    input  wire logic               Clk,
    input  wire logic               Reset,
    counter_mod_n_updown_if.slave   bus
);

    // Top of range; explicit compare is used even when MODULUS == 2**WIDTH.
    localparam logic [WIDTH-1:0]  c_top      = WIDTH'(MODULUS - 1);
    // MODULUS held one bit wider so the range check is valid at MODULUS == 2**WIDTH.
    localparam logic [WIDTH:0]    c_mod_ext  = (WIDTH+1)'(MODULUS);
    localparam logic [WRAP_W-1:0] c_wrap_max = '1;

    logic [WIDTH-1:0]  r_count;
    logic              r_tc;
    logic              r_load_err;
    logic [WRAP_W-1:0] r_wraps;

    logic [WIDTH-1:0]  w_count_next;
    logic              w_tc_next;
    logic              w_err_next;
    logic              w_wrap_evt;
    logic              w_load_oor;

    assign w_load_oor = ({1'b0, bus.Load_Val} >= c_mod_ext);

    // Load beats a step; Tc and Load_Err default low so both are single-cycle
    // unless the same condition recurs on the following edge.
    always_comb begin
        w_count_next = r_count;
        w_tc_next    = 1'b0;
        w_err_next   = 1'b0;
        w_wrap_evt   = 1'b0;
        if (bus.Load) begin
            if (w_load_oor) begin
                w_count_next = c_top;
                w_err_next   = 1'b1;
            end else begin
                w_count_next = bus.Load_Val;
            end
        end else if (bus.En) begin
            if (bus.Up) begin
                if (r_count == c_top) begin
                    w_tc_next = 1'b1;
                    if (!bus.Sat) begin
                        w_count_next = '0;
                        w_wrap_evt   = 1'b1;
                    end
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end else begin
                if (r_count == '0) begin
                    w_tc_next = 1'b1;
                    if (!bus.Sat) begin
                        w_count_next = c_top;
                        w_wrap_evt   = 1'b1;
                    end
                end else begin
                    w_count_next = r_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count    <= '0;
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
            r_wraps    <= '0;
        end else begin
            r_count    <= w_count_next;
            r_tc       <= w_tc_next;
            r_load_err <= w_err_next;
            if (w_wrap_evt && (r_wraps != c_wrap_max)) begin
                r_wraps <= r_wraps + 1'b1;
            end
        end
    end

`ifdef COUNTER_OVF_STICKY_EN
    logic r_ovf;

    // A new overflow takes precedence over a coincident clear.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ovf <= 1'b0;
        end else if (w_wrap_evt && (r_wraps == c_wrap_max)) begin
            r_ovf <= 1'b1;
        end else if (bus.Ovf_Clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.Ovf = r_ovf;
`endif

    assign bus.Count    = r_count;
    assign bus.Tc       = r_tc;
    assign bus.Load_Err = r_load_err;
    assign bus.Wraps    = r_wraps;

endmodule
`default_nettype wire

// File: tb/tb_counter_mod_n_updown.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_mod_n_updown
//  Description : Self-checking bench for counter_mod_n_updown. Two instances
//                share one stimulus stream: d0 (WIDTH 4, MODULUS 10, WRAP_W 2)
//                and d1 (WIDTH 4, MODULUS 16, WRAP_W 3). A behavioural model
//                tracks both and is compared every cycle; directed steps
//                also check hand-computed literals.
//  Options     : COUNTER_OVF_STICKY_EN - also checks the sticky Ovf flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_mod_n_updown;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up;
    logic       sat;
`ifdef COUNTER_OVF_STICKY_EN
    logic       ovf_clr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    counter_mod_n_updown_if #(.WIDTH(4), .WRAP_W(2)) bus0 ();
    counter_mod_n_updown_if #(.WIDTH(4), .WRAP_W(3)) bus1 ();

    assign bus0.En = en;  assign bus0.Up = up;  assign bus0.Sat = sat;
    assign bus0.Load = load;  assign bus0.Load_Val = load_val;
    assign bus1.En = en;  assign bus1.Up = up;  assign bus1.Sat = sat;
    assign bus1.Load = load;  assign bus1.Load_Val = load_val;
`ifdef COUNTER_OVF_STICKY_EN
    assign bus0.Ovf_Clr = ovf_clr;
    assign bus1.Ovf_Clr = ovf_clr;
`endif

    counter_mod_n_updown #(.WIDTH(4), .MODULUS(10), .WRAP_W(2)) u_d0 (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus0)
    );

    counter_mod_n_updown #(.WIDTH(4), .MODULUS(16), .WRAP_W(3)) u_d1 (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: rules applied with plain integer arithmetic.
    // ------------------------------------------------------------------
    int  mod_n [2] = '{10, 16};
    int  wmax  [2] = '{3, 7};
    int  m_cnt [2];
    int  m_tc  [2];
    int  m_err [2];
    int  m_wr  [2];
    int  m_ovf [2];
    bit  m_valid = 1'b0;

    task automatic model_step(input int d);
        int  m;
        bit  terminal;
        bit  wrap_at_max;
        m           = mod_n[d];
        wrap_at_max = 1'b0;
        if (rst) begin
            m_cnt[d] = 0; m_tc[d] = 0; m_err[d] = 0; m_wr[d] = 0; m_ovf[d] = 0;
            return;
        end
        m_tc[d]  = 0;
        m_err[d] = 0;
        if (load) begin
            if (int'(load_val) >= m) begin
                m_cnt[d] = m - 1;
                m_err[d] = 1;
            end else begin
                m_cnt[d] = int'(load_val);
            end
        end else if (en) begin
            terminal = up ? (m_cnt[d] == m - 1) : (m_cnt[d] == 0);
            m_tc[d]  = terminal ? 1 : 0;
            if (sat) begin
                if (!terminal) m_cnt[d] = up ? m_cnt[d] + 1 : m_cnt[d] - 1;
            end else begin
                m_cnt[d] = up ? (m_cnt[d] + 1) % m : (m_cnt[d] + m - 1) % m;
                if (terminal) begin
                    if (m_wr[d] == wmax[d]) wrap_at_max = 1'b1;
                    else                    m_wr[d]++;
                end
            end
        end
`ifdef COUNTER_OVF_STICKY_EN
        if (wrap_at_max)  m_ovf[d] = 1;
        else if (ovf_clr) m_ovf[d] = 0;
`else
        if (wrap_at_max) m_ovf[d] = 1;
`endif
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        if (rst) m_valid = 1'b1;
    end

    // Outputs are compared on the falling edge, away from the update edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("d0.count",    int'(bus0.Count),    m_cnt[0]);
            check("d0.tc",       int'(bus0.Tc),       m_tc[0]);
            check("d0.load_err", int'(bus0.Load_Err), m_err[0]);
            check("d0.wraps",    int'(bus0.Wraps),    m_wr[0]);
            check("d1.count",    int'(bus1.Count),    m_cnt[1]);
            check("d1.tc",       int'(bus1.Tc),       m_tc[1]);
            check("d1.load_err", int'(bus1.Load_Err), m_err[1]);
            check("d1.wraps",    int'(bus1.Wraps),    m_wr[1]);
`ifdef COUNTER_OVF_STICKY_EN
            check("d0.ovf",      int'(bus0.Ovf),      m_ovf[0]);
            check("d1.ovf",      int'(bus1.Ovf),      m_ovf[1]);
`endif
        end
    end

    // Apply one cycle of inputs, then return 1 time unit after the edge.
    task automatic drive(input bit r, input bit l, input int v,
                         input bit e, input bit u, input bit s);
        rst = r; load = l; load_val = 4'(v); en = e; up = u; sat = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b0; sat = 1'b0;
`ifdef COUNTER_OVF_STICKY_EN
        ovf_clr = 1'b0;
`endif
        // Reset with load and enable also active.
        drive(1, 1, 5, 1, 1, 0);
        check("lit.reset.count", int'(bus0.Count), 0);
        check("lit.reset.tc",    int'(bus0.Tc),    0);
        check("lit.reset.wraps", int'(bus0.Wraps), 0);
        check("lit.reset.err",   int'(bus0.Load_Err), 0);

        // Up, wrap mode: 0..9,0,1,2 for d0.
        for (int i = 1; i <= 12; i++) begin
            drive(0, 0, 0, 1, 1, 0);
            check("lit.up.count", int'(bus0.Count), i % 10);
            check("lit.up.tc",    int'(bus0.Tc),    (i == 10) ? 1 : 0);
        end
        check("lit.up.wraps",   int'(bus0.Wraps), 1);
        check("lit.up.d1count", int'(bus1.Count), 12);

        // Down, wrap mode from 0.
        drive(0, 1, 0, 0, 0, 0);
        for (int j = 1; j <= 3; j++) begin
            drive(0, 0, 0, 1, 0, 0);
            check("lit.down.count",   int'(bus0.Count), 10 - j);
            check("lit.down.tc",      int'(bus0.Tc),    (j == 1) ? 1 : 0);
            check("lit.down.d1count", int'(bus1.Count), 16 - j);
        end
        check("lit.down.wraps",   int'(bus0.Wraps), 2);
        check("lit.down.d1wraps", int'(bus1.Wraps), 1);

        // Saturate up from 8.
        drive(0, 1, 8, 0, 1, 1);
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, 1, 1, 1);
            check("lit.satup.count", int'(bus0.Count), 9);
            check("lit.satup.tc",    int'(bus0.Tc),    (k >= 2) ? 1 : 0);
            check("lit.satup.d1",    int'(bus1.Count), 8 + k);
        end
        check("lit.satup.wraps", int'(bus0.Wraps), 2);

        // Saturate down at 0.
        drive(0, 1, 0, 0, 0, 1);
        for (int k = 1; k <= 2; k++) begin
            drive(0, 0, 0, 1, 0, 1);
            check("lit.satdn.count", int'(bus0.Count), 0);
            check("lit.satdn.tc",    int'(bus0.Tc),    1);
        end

        // Out-of-range load (only for d0), then flag drops.
        drive(0, 1, 12, 0, 0, 0);
        check("lit.oor.count",   int'(bus0.Count),    9);
        check("lit.oor.err",     int'(bus0.Load_Err), 1);
        check("lit.oor.d1count", int'(bus1.Count),    12);
        check("lit.oor.d1err",   int'(bus1.Load_Err), 0);
        drive(0, 0, 0, 0, 0, 0);
        check("lit.oor.err_drop", int'(bus0.Load_Err), 0);

        // Load beats an up-step that would otherwise wrap from 9.
        drive(0, 1, 3, 1, 1, 0);
        check("lit.loadpri.count", int'(bus0.Count), 3);
        check("lit.loadpri.tc",    int'(bus0.Tc),    0);
        check("lit.loadpri.wraps", int'(bus0.Wraps), 2);

        // Reset beats load and enable mid-count.
        drive(0, 1, 6, 0, 0, 0);
        drive(1, 1, 12, 1, 1, 0);
        check("lit.rstpri.count", int'(bus0.Count),    0);
        check("lit.rstpri.err",   int'(bus0.Load_Err), 0);
        check("lit.rstpri.wraps", int'(bus0.Wraps),    0);

        // Five full up-wraps on d0: Wraps saturates at 3.
        for (int n = 1; n <= 50; n++) begin
            drive(0, 0, 0, 1, 1, 0);
            if (n == 30) check("lit.wsat.wraps30", int'(bus0.Wraps), 3);
`ifdef COUNTER_OVF_STICKY_EN
            if (n == 39) check("lit.ovf.before", int'(bus0.Ovf), 0);
            if (n == 40) check("lit.ovf.set",    int'(bus0.Ovf), 1);
`endif
        end
        check("lit.wsat.wraps50", int'(bus0.Wraps), 3);
        check("lit.wsat.d1count", int'(bus1.Count), 2);
        check("lit.wsat.d1wraps", int'(bus1.Wraps), 3);

`ifdef COUNTER_OVF_STICKY_EN
        check("lit.ovf.sticky", int'(bus0.Ovf), 1);
        ovf_clr = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        ovf_clr = 1'b0;
        check("lit.ovf.clr", int'(bus0.Ovf), 0);
        for (int n = 1; n <= 9; n++) drive(0, 0, 0, 1, 1, 0);
        ovf_clr = 1'b1;
        drive(0, 0, 0, 1, 1, 0);
        ovf_clr = 1'b0;
        check("lit.ovf.setwins", int'(bus0.Ovf), 1);
`endif

        // Mixed pseudo-random tail, checked by the model only.
        for (int n = 0; n < 300; n++) begin
`ifdef COUNTER_OVF_STICKY_EN
            ovf_clr = ($urandom_range(0, 9) == 0);
`endif
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
